ti_share_recombiner: RTL
========================

Name: ti_share_recombiner

Overview:
- Output-side counterpart of the threshold-implementation (TI) 4-bit S-box share functions. It collects the share words of one masked nibble, arriving one per beat, and XOR-recombines them into the unmasked value.
- Sits at the boundary between the masked S-box datapath and unmasked logic or test readout.
- Checks that each nibble arrives with exactly SHARES beats and flags framing errors.
- Holds one result in an output register while the next nibble accumulates.

Parameters:
- WIDTH, 4, bits per share word (S-box width).
- SHARES, 3, number of shares per masked value; legal range 2..15.
- CNT_W, 4, width of the beat counter; must satisfy 2^CNT_W > SHARES.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  share beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_share  input  WIDTH  share word.
- in_last  input  1  final share beat of the current nibble.
- out_valid  output  1  recombined result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  XOR of all shares of the nibble.
- out_err  output  1  result framing error: beat count differed from SHARES.
- busy  output  1  accumulator holds at least one beat of an unfinished nibble.

Behaviour:
- Reset: on clk edge with rst=1, acc=0, cnt=0, out_valid=0, out_data=0, out_err=0, busy=0.
- rst has priority over every other event. A nibble that is partially accumulated when reset arrives is discarded, and so is a pending output.
- Beat accept: a beat is accepted when in_valid & in_ready.
- in_ready = !(out_valid & !out_ready) | !accept_would_complete.
  - Beats that do not end a nibble are always accepted.
  - A completing beat (in_last=1, or cnt==SHARES-1 with in_last=0, see overflow) stalls only while the output register is full and not being drained this cycle.
- Accumulation:
  - On a non-final accept: acc <= acc ^ in_share, cnt <= cnt+1, busy=1.
  - cnt saturates at 2^CNT_W-1.
- Completion on an accept with in_last=1:
  - out_data <= acc ^ in_share.
  - out_err <= (cnt+1 != SHARES).
  - out_valid <= 1.
  - acc <= 0, cnt <= 0, busy <= 0.
- Overflow: an accept with in_last=0 when cnt==SHARES-1 is treated as forced completion.
  - Result out_data = acc ^ in_share, out_err=1.
  - Following beats up to and including the next in_last are dropped: state DRAIN, in_ready=1, no accumulation. DRAIN exits to IDLE after the in_last beat.
- States:
  - IDLE (cnt=0): first beat goes to ACC, or directly completes if in_last=1. A single-beat nibble gives out_err=1 when SHARES>1.
  - ACC: accumulate until completion or overflow.
  - DRAIN: as above.
- Latency: result is visible on out_data/out_valid the cycle after the completing beat is accepted.
- Output handshake:
  - out_valid holds until out_valid & out_ready.
  - out_data and out_err are stable while out_valid=1 and out_ready=0.
- Simultaneous drain and complete: if the output is taken in the same cycle a new completing beat is accepted, out_valid stays 1 with the new data (full throughput).
- in_valid=0: no state change except the output drain.
- No arithmetic beyond XOR. Width is WIDTH throughout; no carries.

Test Plan:
- SHARES=3, beats 4'h3, 4'h5, 4'h9(last), out_ready=1 -> one cycle after the last beat: out_valid=1, out_data=4'hF, out_err=0; busy=1 during beats 1-2.
- Back-to-back nibbles (3,5,9 last)(A,A,0 last) with out_ready held 0 for 4 cycles after the first result -> out_data=F holds. in_ready=0 only on the second nibble's last beat until out_ready=1, then out_data=0, out_err=0.
- Short frame 4'h6, 4'h1(last) -> out_data=4'h7, out_err=1; next nibble 1,2,4(last) -> out_data=4'h7, out_err=0.
- Overflow 1,2,4,8,F(last) -> result out_data=4'h7, out_err=1 after beat 3. Beats 8 and F are dropped (DRAIN); the next nibble accumulates from zero.
- rst asserted after two beats of 3,5 -> busy=0, out_valid=0; then 9,9,9(last) -> out_data=4'h9, out_err=0.
- Randomised: 1000 nibbles, random SHARES-split masks of random values, random in_valid/out_ready gaps -> every out_data equals the unmasked value, zero out_err, no lost or duplicated results.

Source files
------------

// File: rtl/ti_share_recombiner.sv
// Collects the share words of one masked nibble, one per beat, and XOR-recombines them.
// The beat count of each nibble is checked, and the result is held in an output register.
module ti_share_recombiner #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SHARES = 3,
    parameter int unsigned CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_share,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHARES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_DRAIN
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_err_q, out_err_d;
    logic               out_free;
    logic               completing;
    logic               accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

    // A beat that ends the nibble (explicitly or by overflow) needs room in the output register.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;

        out_free   = !out_valid_q || out_ready;
        completing = (state_q != ST_DRAIN) && (in_last || (cnt_q == LAST_CNT));
        in_ready   = out_free || !completing;
        accept     = in_valid && in_ready;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_ACC: begin
                if (accept) begin
                    if (completing) begin
                        out_valid_d = 1'b1;
                        out_data_d  = acc_q ^ in_share;
                        out_err_d   = in_last ? (cnt_q != LAST_CNT) : 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        busy_d      = 1'b0;
                        state_d     = in_last ? ST_IDLE : ST_DRAIN;
                    end else begin
                        acc_d   = acc_q ^ in_share;
                        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                        busy_d  = 1'b1;
                        state_d = ST_ACC;
                    end
                end
            end
            ST_DRAIN: begin
                // Excess beats of an overflowed nibble are discarded up to its last beat.
                if (accept && in_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign busy      = busy_q;

endmodule
